// File: rtl/charlieplex_scroller.sv
// Column FIFO and scroll engine feeding a 7x5 charlieplex display over Wishbone.
// The CPU pushes 5-bit columns; each scroll tick shifts one into the frame and rewrites all five rows.
module charlieplex_scroller #(
  parameter int pClkHz    = 0,
  parameter int pScrollHz = 10,
  parameter int pDepth    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_stb,
  input  logic        s_we,
  input  logic [3:0]  s_adr,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack,
  output logic        m_stb,
  output logic        m_we,
  output logic [3:0]  m_adr,
  output logic [31:0] m_dat,
  input  logic        m_ack
);

  // A degenerate clock/scroll ratio collapses to a tick on every cycle.
  localparam int PRaw = (pScrollHz > 0) ? (pClkHz / pScrollHz) : 1;
  localparam int P    = (PRaw < 1) ? 1 : PRaw;
  localparam int CW   = (P > 1) ? $clog2(P) : 1;
  localparam int AW   = (pDepth > 1) ? $clog2(pDepth) : 1;
  localparam logic [CW-1:0] TickMax  = CW'(P - 1);
  localparam logic [AW:0]   DepthVal = (AW + 1)'(pDepth);

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StShift,
    StWrite,
    StWait,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [4:0]      frame_q [0:6];
  logic [4:0]      frame_d [0:6];
  logic [4:0]      col_q, col_d;
  logic [CW-1:0]   cnt_q;
  logic            pause_q;
  logic            ovf_q, ovf_d;
  logic            flushPend_q;
  logic            sAck_q;
  logic [31:0]     sDat_q, sDat_d;
  logic [4:0]      mem_q [0:pDepth-1];
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [AW:0]     count_q;

  logic tick, access, wrAcc, rdAcc;
  logic push, doPush, pop, fifoClear, flushReq, pauseWr, statusRd;
  logic full, empty, mStb;
  logic [6:0] rowBits;

  assign tick     = (cnt_q == TickMax);
  assign access   = s_stb & ~sAck_q;
  assign wrAcc    = access & s_we;
  assign rdAcc    = access & ~s_we;
  assign push     = wrAcc & (s_adr == 4'd0);
  assign flushReq = wrAcc & (s_adr == 4'd1) & s_dat_i[0];
  assign pauseWr  = wrAcc & (s_adr == 4'd2);
  assign statusRd = rdAcc & (s_adr == 4'd1);
  assign full     = (count_q == DepthVal);
  assign empty    = (count_q == '0);
  assign doPush   = push & ~fifoClear & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    sDat_d = '0;
    if (rdAcc) begin
      case (s_adr)
        4'd1:    sDat_d = {23'b0, ovf_q, full, empty, 6'(count_q)};
        4'd2:    sDat_d = {31'b0, pause_q};
        default: sDat_d = '0;
      endcase
    end
    ovf_d = ovf_q;
    if (push & ~doPush & ~fifoClear) begin
      ovf_d = 1'b1;
    end else if (statusRd) begin
      ovf_d = 1'b0;
    end
  end

  // Slave side: one ack per strobe, and the register access lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sAck_q      <= 1'b0;
      sDat_q      <= '0;
      pause_q     <= 1'b0;
      ovf_q       <= 1'b0;
      flushPend_q <= 1'b0;
    end else begin
      sAck_q <= s_stb & ~sAck_q;
      if (access) begin
        sDat_q <= sDat_d;
      end
      if (pauseWr) begin
        pause_q <= s_dat_i[0];
      end
      ovf_q       <= ovf_d;
      flushPend_q <= (flushPend_q & ~fifoClear) | flushReq;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= s_dat_i[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fifoClear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      row_q   <= '0;
      col_q   <= '0;
      for (int c = 0; c < 7; c++) begin
        frame_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

  // A pending flush is only honoured from IDLE, so an in-flight refresh always completes first.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    frame_d   = frame_q;
    pop       = 1'b0;
    fifoClear = 1'b0;
    case (state_q)
      StClear: begin
        for (int c = 0; c < 7; c++) begin
          frame_d[c] = '0;
        end
        row_d   = '0;
        state_d = StWrite;
      end
      StIdle: begin
        if (flushPend_q) begin
          fifoClear = 1'b1;
          state_d   = StClear;
        end else if (tick && !pause_q && !empty) begin
          pop     = 1'b1;
          col_d   = mem_q[rdPtr_q];
          state_d = StShift;
        end
      end
      StShift: begin
        for (int c = 0; c < 6; c++) begin
          frame_d[c] = frame_q[c+1];
        end
        frame_d[6] = col_q;
        row_d      = '0;
        state_d    = StWrite;
      end
      StWrite: state_d = StWait;
      StWait: begin
        if (m_ack) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (row_q == 3'd4) begin
          state_d = StIdle;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = StWrite;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    rowBits = '0;
    for (int c = 0; c < 7; c++) begin
      rowBits[c] = frame_q[c][row_q];
    end
  end

  assign mStb    = (state_q == StWrite) || (state_q == StWait);
  assign m_stb   = mStb;
  assign m_we    = 1'b1;
  assign m_adr   = mStb ? {1'b0, row_q} : 4'd0;
  assign m_dat   = mStb ? {25'b0, rowBits} : 32'd0;
  assign s_ack   = sAck_q;
  assign s_dat_o = sDat_q;

endmodule

// File: tb/tb_charlieplex_scroller.sv
// Directed bench for charlieplex_scroller: CPU register accesses, scrolled frame contents,
// FIFO full/overflow handling, empty ticks, a stalled display ack and reset mid-transaction.
module tb_charlieplex_scroller;

  localparam int ClkHz    = 400;
  localparam int ScrollHz = 10;
  localparam int Depth    = 16;
  localparam int P        = ClkHz / ScrollHz;

  typedef struct packed {
    logic            flush;
    logic [4:0]      col;
    logic [4:0][7:0] rows;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_stb = 1'b0;
  logic        s_we = 1'b0;
  logic [3:0]  s_adr = 4'd0;
  logic [31:0] s_dat_i = 32'd0;
  logic [31:0] s_dat_o;
  logic        s_ack;
  logic        m_stb;
  logic        m_we;
  logic [3:0]  m_adr;
  logic [31:0] m_dat;
  logic        m_ack = 1'b0;

  logic        stallRow2 = 1'b0;
  logic [3:0]  wrAdrQ[$];
  logic [31:0] wrDatQ[$];
  int          stbCycles = 0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[5];

  charlieplex_scroller #(
    .pClkHz(ClkHz),
    .pScrollHz(ScrollHz),
    .pDepth(Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_stb(s_stb),
    .s_we(s_we),
    .s_adr(s_adr),
    .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o),
    .s_ack(s_ack),
    .m_stb(m_stb),
    .m_we(m_we),
    .m_adr(m_adr),
    .m_dat(m_dat),
    .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  // Display model: acks one cycle after strobe, except when row 2 is being stalled.
  always @(posedge clk) begin
    m_ack <= m_stb & ~(stallRow2 & (m_adr == 4'd2));
  end

  always @(negedge clk) begin
    if (m_stb && m_ack) begin
      wrAdrQ.push_back(m_adr);
      wrDatQ.push_back(m_dat);
    end
    if (m_stb) begin
      stbCycles++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busAccess(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    int k;
    @(negedge clk);
    s_stb = 1'b1;
    s_we = we;
    s_adr = adr;
    s_dat_i = wdat;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_ack && k < 4);
    checkOutput($sformatf("ack adr%0d", adr), 32'(s_ack), 32'd1);
    rdat = s_dat_o;
    s_stb = 1'b0;
    s_we = 1'b0;
  endtask

  task automatic busWrite(input logic [3:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    busAccess(1'b1, adr, dat, dummy);
  endtask

  task automatic busReadCheck(input string name, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    busAccess(1'b0, adr, 32'd0, rd);
    checkOutput(name, rd, exp);
  endtask

  task automatic waitWrites(input int target, input int budget, input string name);
    int k = 0;
    while (wrAdrQ.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, " write count"}, 32'(wrAdrQ.size() >= target), 32'd1);
  endtask

  task automatic checkRefresh(input int base, input logic [4:0][7:0] exp, input string tag);
    for (int i = 0; i < 5; i++) begin
      if (base + i < wrAdrQ.size()) begin
        checkOutput($sformatf("%s adr row%0d", tag, i), 32'(wrAdrQ[base+i]), 32'(i));
        checkOutput($sformatf("%s dat row%0d", tag, i), wrDatQ[base+i], {24'd0, exp[i]});
      end
    end
  endtask

  // Push one column (optionally after a flush) and compare the refresh it triggers.
  task automatic applyStimulus(input vec_t v, input int idx);
    int base;
    if (v.flush) begin
      base = wrAdrQ.size();
      busWrite(4'd1, 32'd1);
      waitWrites(base + 5, 60, "flush");
      checkRefresh(base, '0, "flush");
    end
    base = wrAdrQ.size();
    busWrite(4'd0, {27'd0, v.col});
    waitWrites(base + 5, 2 * P + 40, $sformatf("vec%0d", idx));
    checkRefresh(base, v.rows, $sformatf("vec%0d", idx));
    busReadCheck($sformatf("vec%0d status", idx), 4'd1, 32'h40);
  endtask

  initial begin
    int base;
    int snap;
    int k;

    vecs[0] = '{flush: 1'b0, col: 5'h1F, rows: {8'h40, 8'h40, 8'h40, 8'h40, 8'h40}};
    vecs[1] = '{flush: 1'b1, col: 5'h01, rows: {8'h00, 8'h00, 8'h00, 8'h00, 8'h40}};
    vecs[2] = '{flush: 1'b0, col: 5'h02, rows: {8'h00, 8'h00, 8'h00, 8'h40, 8'h20}};
    vecs[3] = '{flush: 1'b0, col: 5'h04, rows: {8'h00, 8'h00, 8'h40, 8'h20, 8'h10}};
    vecs[4] = '{flush: 1'b0, col: 5'h11, rows: {8'h40, 8'h00, 8'h20, 8'h10, 8'h48}};

    // Reset with a strobe held: neither bus may respond.
    s_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset s_ack", 32'(s_ack), 32'd0);
      checkOutput("reset m_stb", 32'(m_stb), 32'd0);
    end
    s_stb = 1'b0;
    base = wrAdrQ.size();
    @(negedge clk);
    rst = 1'b0;
    waitCycles(30);
    checkOutput("post-reset write count", 32'(wrAdrQ.size() - base), 32'd5);
    checkRefresh(base, '0, "clear");

    busReadCheck("status empty", 4'd1, 32'h40);
    busReadCheck("adr0 read", 4'd0, 32'd0);
    busWrite(4'd5, 32'hFFFF_FFFF);
    busReadCheck("adr5 read", 4'd5, 32'd0);
    busReadCheck("pause reset", 4'd2, 32'd0);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v], v);
    end

    // Fill past capacity while paused.
    busWrite(4'd2, 32'd1);
    busReadCheck("pause set", 4'd2, 32'd1);
    base = wrAdrQ.size();
    for (int i = 0; i < Depth + 2; i++) begin
      busWrite(4'd0, 32'(i + 1));
    end
    busReadCheck("status overflow", 4'd1, 32'h190);
    busReadCheck("status overflow cleared", 4'd1, 32'h090);
    checkOutput("paused writes", 32'(wrAdrQ.size() - base), 32'd0);

    base = wrAdrQ.size();
    busWrite(4'd2, 32'd0);
    waitWrites(base + 80, 17 * P + 60, "drain");
    checkRefresh(base + 75, {8'h40, 8'h3F, 8'h3C, 8'h33, 8'h2A}, "drain last");
    waitCycles(P + 10);
    checkOutput("drain total writes", 32'(wrAdrQ.size() - base), 32'd80);
    busReadCheck("status drained", 4'd1, 32'h40);

    // Ticks with an empty FIFO must leave the display and frame alone.
    snap = stbCycles;
    waitCycles(2 * P);
    checkOutput("empty tick stb", 32'(stbCycles - snap), 32'd0);
    base = wrAdrQ.size();
    busWrite(4'd0, 32'h03);
    waitWrites(base + 5, 2 * P + 40, "after empty");
    checkRefresh(base, {8'h20, 8'h1F, 8'h1E, 8'h59, 8'h55}, "after empty");

    // Stall the display on row 2, then reset in the middle of the transaction.
    stallRow2 = 1'b1;
    base = wrAdrQ.size();
    busWrite(4'd0, 32'h1F);
    k = 0;
    while (!(m_stb && m_adr == 4'd2) && k < 2 * P + 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("stall reached row2", 32'(m_stb && m_adr == 4'd2), 32'd1);
    checkRefresh(base, {8'h00, 8'h00, 8'h00, 8'h6C, 8'h6A}, "pre-stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall m_stb", 32'(m_stb), 32'd1);
      checkOutput("stall m_adr", 32'(m_adr), 32'd2);
      checkOutput("stall m_dat", m_dat, 32'h4F);
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-stall reset m_stb", 32'(m_stb), 32'd0);
    stallRow2 = 1'b0;
    base = wrAdrQ.size();
    @(negedge clk);
    rst = 1'b0;
    waitWrites(base + 5, 40, "reclear");
    checkRefresh(base, '0, "reclear");
    busReadCheck("status after reset", 4'd1, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/charlieplex_scroller.md
Name: charlieplex_scroller

Overview:
- Upstream feeder for the 7x5 charlieplex display peripheral.
- CPU-side Wishbone slave accepts 5-bit pixel columns into a FIFO.
- At a fixed scroll rate the block pops one column and shifts it into a 7-column frame.
- A Wishbone master then rewrites the display's five row registers (adr 0..4, dat[6:0] = row bits, bit c = column c).

Parameters:
- pClkHz, 0, system clock frequency in Hz; must be >= pScrollHz.
- pScrollHz, 10, scroll steps per second; tick period P = pClkHz/pScrollHz cycles.
- pDepth, 16, column FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_stb  in  1  slave strobe from CPU bus.
- s_we  in  1  slave write enable.
- s_adr  in  4  slave word address.
- s_dat_i  in  32  slave write data.
- s_dat_o  out  32  slave read data.
- s_ack  out  1  slave acknowledge.
- m_stb  out  1  master strobe to display.
- m_we  out  1  master write enable; tied 1.
- m_adr  out  4  master address, row index 0..4.
- m_dat  out  32  master write data; bits [31:7] always 0.
- m_ack  in  1  display acknowledge.

Behaviour:
- Reset values: all outputs 0; FIFO empty; frame all zero; overflow flag 0; tick counter 0; state CLEAR.
- Slave interface:
  - s_ack <= s_stb & ~s_ack, so there is exactly one ack pulse per access, one cycle after stb.
  - The access is performed on the cycle s_ack is set.
- Register map:
  - adr 0 write: push s_dat_i[4:0]; bit r = row r lit.
  - adr 0 read: returns 0.
  - adr 1 read: {23'b0, overflow, full, empty, level[5:0]}; level is 0..pDepth.
  - adr 1 write with dat[0]=1: flush FIFO and zero the frame; takes effect at the next refresh.
  - adr 2 read/write: bit0 = pause.
  - All other addresses read 0; writes to them are ignored.
- FIFO behaviour:
  - Push when full: data dropped, overflow set.
  - Overflow is sticky and clears on the cycle a read of adr 1 is acked.
  - Pop and push in the same cycle: both happen and level is unchanged.
  - A push into an empty FIFO is visible (empty=0) one cycle after ack.
- Tick counter:
  - Counts 0..P-1 and wraps.
  - tick = (cnt == P-1), a one-cycle pulse.
  - Counter runs regardless of state or pause.
- State machine:
  - CLEAR: frame = 0; go to WRITE with row = 0. Entered after reset and after a flush.
  - IDLE: on tick with ~pause and ~empty, pop one column and go to SHIFT. A tick with empty or pause is ignored; no writes occur and the frame is unchanged.
  - SHIFT: frame column c <= column c+1 for c = 0..5; column 6 <= popped data. Set row = 0; go to WRITE.
  - WRITE: m_stb=1, m_adr=row, m_dat[6:0] = {frame[6][row], ..., frame[0][row]}. Go to WAIT.
  - WAIT: hold stb/adr/dat stable until m_ack. On the cycle m_ack=1, drop m_stb next cycle and go to GAP.
  - GAP: one idle cycle with m_stb=0. If row==4 go to IDLE, else row+1 and go to WRITE.
- Timing and event rules:
  - A refresh takes at least 15 cycles (5 x WRITE/WAIT/GAP with a 1-cycle ack). A tick arriving before return to IDLE is lost; no tick queueing.
  - A flush requested mid-refresh is latched, and CLEAR runs after the current refresh completes.
  - Reset mid-transaction drops m_stb on the next edge and restarts in CLEAR (the display is rewritten with zeros).

Test Plan:
- Reset then run 30 cycles with m_ack = registered m_stb → exactly 5 writes, adr 0..4, dat 0; s_ack/m_stb low during reset.
- Push 0x1F via adr 0, wait one tick → 5 writes each with dat=0x40; status level returns 0.
- Push 0x01,0x02,0x04 across 3 ticks → final refresh: row0=0x10, row1=0x20, row2=0x40, rows 3/4=0x00.
- Push pDepth+2 columns with pause=1 → status full=1, overflow=1, level=16. Read status again → overflow=0. Unpause: 16 pops over 16 ticks.
- Tick with empty FIFO → no m_stb for the following P cycles; frame unchanged on the next refresh after a push.
- Stall m_ack for 10 cycles on row 2 → m_stb/m_adr/m_dat held constant; assert rst mid-stall → m_stb 0 next cycle, then CLEAR writes zeros to all 5 rows.
